dm_stage_pipe: RTL

//  Parametrised data-memory pipeline stage for the MIPS datapath, between EX and WB.

---
 rtl/dm_stage_pipe_if.sv | 27 ++
 rtl/dm_stage_pipe.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dm_stage_pipe_if.sv
// Handshake/bus bundle between EX, the data-memory stage and WB.
interface dm_stage_pipe_if #(
    parameter int DATA_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [DATA_W-1:0]     in_addr;
    logic [DATA_W-1:0]     in_wdata;
    logic [DATA_W/8-1:0]   in_be;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  out_fault;

    // Upstream/downstream side: issues ops and consumes results
    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_be, out_ready,
        input  in_ready, out_valid, out_data, out_fault
    );

    // Stage side
    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_be, out_ready,
        output in_ready, out_valid, out_data, out_fault
    );
endinterface

// File: rtl/dm_stage_pipe.sv
// Data-memory pipeline stage: pass-through, word load or byte-enabled store
// on an internal synchronous RAM, with valid/ready handshake, range fault
// detection and an optional post-reset RAM clear sweep.
module dm_stage_pipe #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            reset,
    dm_stage_pipe_if.slave  bus,
    output logic            busy
);
    localparam int NB = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_fault;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic              w_in_ready;
    logic              w_accept;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_hi_nz;
    logic              w_fault;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [NB-1:0]     w_mem_be;
    logic [DATA_W-1:0] w_mem_wdata;

    // Address bits above the RAM index must be zero; no aliasing onto low words
    if (ADDR_W < DATA_W) begin : g_hi
        assign w_hi_nz = |bus.in_addr[DATA_W-1:ADDR_W];
    end else begin : g_nohi
        assign w_hi_nz = 1'b0;
    end

    assign w_idx      = bus.in_addr[ADDR_W-1:0];
    assign w_is_load  = (bus.in_op == OP_LOAD);
    assign w_is_store = (bus.in_op == OP_STORE);
    assign w_fault    = (w_is_load | w_is_store) & w_hi_nz;
    assign w_in_ready = (r_state == ST_RUN) & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_fault = r_out_fault;
    assign busy          = (r_state == ST_CLEAR);

    // Clear-sweep sequencer: walks every index once, then enters RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_state <= ST_RUN;
            end
        end
    end

    // RAM write port select: sweep zeroes whole words, stores use byte enables
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_idx;
        w_mem_be    = bus.in_be;
        w_mem_wdata = bus.in_wdata;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_cnt;
                w_mem_be    = '1;
                w_mem_wdata = '0;
            end else if (w_accept && w_is_store && !w_fault) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Byte-lane RAM write
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_mem_be[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Output register: load on accept, drop valid when consumed, hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_fault <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_fault <= w_fault;
            if (w_is_load) begin
                r_out_data <= w_fault ? '0 : r_mem[w_idx];
            end else if (w_is_store) begin
                r_out_data <= '0;
            end else begin
                r_out_data <= bus.in_addr;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
